control_sequencer: RTL and testbench
====================================

# control_sequencer

Fetch/decode/execute sequencer for the adding machine. It sits directly upstream of the 6-bit program counter and drives its `clear`, `inc_pc`, `load_pc` and `data_in_pc` inputs. It reads the counter's `out_pc` back to address instruction fetches. It also owns the 8-bit accumulator and carry flag, and reads program/data memory through a req/ack handshake.

## Interface
- No parameters. Widths are fixed: address 6 bits, data/instruction 8 bits.
- `clock`  in  1  rising-edge system clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `start`  in  1  begin execution from address 0; honoured only in IDLE or HALT
- `pc_value`  in  6  current program counter value (`out_pc`)
- `clear_pc`  out  1  to PC `clear`
- `inc_pc`  out  1  to PC `inc_pc`
- `load_pc`  out  1  to PC `load_pc`
- `pc_jump_addr`  out  6  to PC `data_in_pc`; always equals `ir[5:0]`
- `mem_rd_req`  out  1  memory read request
- `mem_addr`  out  6  memory read address
- `mem_rd_ack`  in  1  read data valid this cycle
- `mem_rd_data`  in  8  read data
- `acc`  out  8  accumulator
- `carry`  out  1  carry out of the last ADD
- `busy`  out  1  high in FETCH, DECODE and OPER
- `halted`  out  1  high in HALT

## Operation
- Instruction format: `ir[7:6]` is the opcode, `ir[5:0]` is the operand address.
  - 00 = LDA (`acc` ← mem[addr])
  - 01 = ADD (`{carry,acc}` ← `acc` + mem[addr])
  - 10 = JMP (PC ← addr)
  - 11 = HLT
- States are IDLE, FETCH, DECODE, OPER and HALT.
- IDLE / HALT:
  - If `start`=1: pulse `clear_pc` for 1 cycle, clear `acc` and `carry` to 0, then go to FETCH.
  - Otherwise stay.
- FETCH:
  - `mem_rd_req`=1 and `mem_addr`=`pc_value`.
  - When `mem_rd_ack`=1: `ir` ← `mem_rd_data`, `inc_pc`=1 in that same cycle, go to DECODE.
  - Otherwise hold.
- DECODE:
  - LDA or ADD: go to OPER.
  - JMP: `load_pc`=1 for this one cycle, go to FETCH.
  - HLT: go to HALT.
- OPER:
  - `mem_rd_req`=1 and `mem_addr`=`ir[5:0]`.
  - On ack with LDA: `acc` ← data; `carry` is unchanged.
  - On ack with ADD: 9-bit sum, low 8 bits to `acc`, bit 8 to `carry` (wraps modulo 256).
  - After the ack, go to FETCH.
- Outside FETCH, `mem_addr` = `ir[5:0]`.
- `clear_pc`, `inc_pc` and `load_pc` are combinational from state and inputs. At most one of them is high in any cycle.
- `acc`, `carry`, `ir` and the state register are registered.

## Timing
- Reset (asynchronous, `reset`=0):
  - State → IDLE; `ir`, `acc` and `carry` → 0.
  - `mem_rd_req`, `clear_pc`, `inc_pc`, `load_pc`, `busy` and `halted` are 0.
  - `mem_addr` and `pc_jump_addr` are 0.
  - Applies immediately, mid-transaction included. An outstanding request is dropped and a late ack is ignored.
- Handshake:
  - `mem_rd_req` stays high and `mem_addr` stays stable until the edge at which `mem_rd_ack`=1 is sampled.
  - Ack in the same cycle as the first req cycle is legal (zero wait).
  - Ack while `mem_rd_req`=0 is ignored.
  - `mem_rd_req` drops for at least the DECODE cycle between fetch and operand read.
- PC coupling: the PC increments on the same edge that captures `ir`. In DECODE, `pc_value` therefore already points to the next instruction.
- Zero-wait latency, counted from entering FETCH:
  - LDA/ADD: 3 cycles, with `acc` updated at the end of cycle 3.
  - JMP: 2 cycles, with the new PC visible in the next FETCH.
  - HLT: 2 cycles to `halted`=1.
  - Each wait cycle adds 1.
- PC wrap (63 → 0) is the PC's concern. The sequencer keeps fetching with no special case.
- `start` while `busy` is ignored. `start` held high through HALT restarts execution.

## Test plan
- Reset/start:
  - Hold `reset`=0 → all outputs 0, `busy`=0.
  - Release, pulse `start` → `clear_pc`=1 for exactly 1 cycle, then `mem_rd_req`=1 with `mem_addr`=0.
- LDA/ADD:
  - Memory: [0]=0x05 (LDA 5), [1]=0x46 (ADD 6), [2]=0xC0 (HLT), [5]=0x20, [6]=0x13, zero wait.
  - Expect `acc`=0x20, then 0x33, `carry`=0, and `halted` after 8 cycles from the first FETCH.
- Carry wrap: [5]=0xF0, [6]=0x25 → `acc`=0x15, `carry`=1.
- JMP: [0]=0x83 (JMP 3), [3]=0xC0 → `load_pc`=1 with `pc_jump_addr`=3 in DECODE, next fetch address 3, then `halted`.
- Wait states:
  - Delay each ack by 3 cycles → `mem_addr`/`mem_rd_req` stable throughout, `inc_pc` pulses once per instruction.
  - A spurious ack in DECODE has no effect.
- Reset mid-OPER: assert `reset`=0 while `mem_rd_req`=1 → `mem_rd_req`=0 immediately, `acc`=0, state IDLE. A subsequent ack is ignored.

Source files
------------

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the adding machine: drives the 6-bit PC, owns acc/carry/ir.
// Latency from FETCH entry, zero wait: LDA/ADD 3 cycles, JMP 2, HLT 2; each memory wait cycle adds 1.
// Backpressure: mem_rd_req and mem_addr are held stable until mem_rd_ack is sampled; acks without a request are ignored.
module control_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] pc_value,
    output logic       clear_pc,
    output logic       inc_pc,
    output logic       load_pc,
    output logic [5:0] pc_jump_addr,
    output logic       mem_rd_req,
    output logic [5:0] mem_addr,
    input  logic       mem_rd_ack,
    input  logic [7:0] mem_rd_data,
    output logic [7:0] acc,
    output logic       carry,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_OPER   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_LDA = 2'b00,
        OP_ADD = 2'b01,
        OP_JMP = 2'b10,
        OP_HLT = 2'b11
    } opcode_t;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic       carry_q, carry_d;

    opcode_t    opcode;
    logic [5:0] operand;
    logic [8:0] sum;

    assign opcode  = opcode_t'(ir_q[7:6]);
    assign operand = ir_q[5:0];
    // Carry out is bit 8 of the zero-extended sum; the low byte wraps modulo 256.
    assign sum     = {1'b0, acc_q} + {1'b0, mem_rd_data};

    // State, instruction and datapath registers; reset drops any in-flight request at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ir_q    <= 8'h00;
            acc_q   <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    // Next-state logic plus all combinational controls toward the PC and memory.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        clear_pc   = 1'b0;
        inc_pc     = 1'b0;
        load_pc    = 1'b0;
        mem_rd_req = 1'b0;
        mem_addr   = operand;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                // Restart from address 0 with a clean accumulator.
                if (start) begin
                    clear_pc = 1'b1;
                    acc_d    = 8'h00;
                    carry_d  = 1'b0;
                    state_d  = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_rd_req = 1'b1;
                mem_addr   = pc_value;
                // PC advances on the same edge that captures the instruction.
                if (mem_rd_ack) begin
                    ir_d    = mem_rd_data;
                    inc_pc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                unique case (opcode)
                    OP_LDA, OP_ADD: state_d = ST_OPER;
                    OP_JMP: begin
                        load_pc = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_HLT:         state_d = ST_HALT;
                    default:        state_d = ST_HALT;
                endcase
            end

            ST_OPER: begin
                mem_rd_req = 1'b1;
                if (mem_rd_ack) begin
                    if (opcode == OP_ADD) begin
                        acc_d   = sum[7:0];
                        carry_d = sum[8];
                    end else begin
                        acc_d   = mem_rd_data;
                    end
                    state_d = ST_FETCH;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign pc_jump_addr = operand;
    assign acc          = acc_q;
    assign carry        = carry_q;
    assign busy         = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_OPER);
    assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: PC and memory models, ISA-level reference, scoreboard monitor.
// Each run resolves within a bounded number of cycles; a global watchdog ends a hung run.
// Memory acks are delayed by a fixed or random number of wait cycles, with optional spurious acks.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] pc_value;
    logic       clear_pc, inc_pc, load_pc;
    logic [5:0] pc_jump_addr;
    logic       mem_rd_req;
    logic [5:0] mem_addr;
    logic       mem_rd_ack = 1'b0;
    logic [7:0] mem_rd_data = 8'h00;
    logic [7:0] acc;
    logic       carry, busy, halted;

    control_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pc_value     (pc_value),
        .clear_pc     (clear_pc),
        .inc_pc       (inc_pc),
        .load_pc      (load_pc),
        .pc_jump_addr (pc_jump_addr),
        .mem_rd_req   (mem_rd_req),
        .mem_addr     (mem_addr),
        .mem_rd_ack   (mem_rd_ack),
        .mem_rd_data  (mem_rd_data),
        .acc          (acc),
        .carry        (carry),
        .busy         (busy),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] addr;
        bit         oper;
        logic [7:0] acc;
        bit         carry;
    } exp_t;

    logic [7:0] mem [64];
    exp_t       exp_q[$];
    int         checks    = 0;
    int         failures  = 0;
    bit         mon_en    = 1'b0;
    bit         spur_en   = 1'b0;
    bit         force_ack = 1'b0;
    int         wmode     = 0;
    logic [7:0] exp_acc;
    logic       exp_carry;
    int         inc_cnt   = 0;
    int         jmp_cnt   = 0;
    logic [5:0] jmp_addr  = 6'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Program counter model: clear beats load beats increment.
    logic [5:0] pc_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        pc_q <= 6'd0;
        else if (clear_pc) pc_q <= 6'd0;
        else if (load_pc)  pc_q <= pc_jump_addr;
        else if (inc_pc)   pc_q <= pc_q + 6'd1;
    end
    assign pc_value = pc_q;

    // Memory model: answers a held request after a chosen number of wait cycles.
    int wcnt = 0;
    int cur_wait = 0;
    function automatic int pick_wait();
        return (wmode < 4) ? wmode : int'($urandom_range(0, 3));
    endfunction

    always @(negedge clock) begin
        if (force_ack) begin
            mem_rd_ack  = 1'b1;
            mem_rd_data = 8'hA5;
            wcnt        = 0;
        end else if (!reset) begin
            mem_rd_ack = 1'b0;
            wcnt       = 0;
        end else if (mem_rd_req) begin
            if (wcnt == 0) cur_wait = pick_wait();
            if (wcnt >= cur_wait) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = mem[mem_addr];
                wcnt        = 0;
            end else begin
                mem_rd_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_rd_ack  = spur_en && ($urandom_range(0, 2) == 0);
            mem_rd_data = 8'($urandom);
            wcnt        = 0;
        end
    end

    // Reference: execute the program at instruction level, listing every expected read.
    task automatic build_expect();
        logic [5:0] pc = 6'd0;
        logic [7:0] a  = 8'h00;
        logic       c  = 1'b0;
        logic [8:0] s;
        logic [7:0] ins;
        exp_q.delete();
        for (int k = 0; k < 500; k++) begin
            ins = mem[pc];
            exp_q.push_back('{pc, 1'b0, 8'h00, 1'b0});
            pc = pc + 6'd1;
            if (ins[7:6] == 2'b00) begin
                a = mem[ins[5:0]];
                exp_q.push_back('{ins[5:0], 1'b1, a, c});
            end else if (ins[7:6] == 2'b01) begin
                s = {1'b0, a} + {1'b0, mem[ins[5:0]]};
                a = s[7:0];
                c = s[8];
                exp_q.push_back('{ins[5:0], 1'b1, a, c});
            end else if (ins[7:6] == 2'b10) begin
                pc = ins[5:0];
            end else begin
                break;
            end
        end
        exp_acc   = a;
        exp_carry = c;
    endtask

    // Monitor: pops the scoreboard on every accepted read and checks handshake rules.
    bit         prev_req = 1'b0;
    bit         prev_hs  = 1'b0;
    bit         acc_pend = 1'b0;
    bit         hs;
    logic [5:0] prev_addr = 6'd0;
    exp_t       pend;
    exp_t       e;
    int         nctl;

    always begin
        @(negedge clock);
        #2;
        if (!mon_en || !reset) begin
            prev_req = 1'b0;
            prev_hs  = 1'b0;
            acc_pend = 1'b0;
        end else begin
            if (acc_pend) begin
                chk("acc_after_oper", acc, pend.acc);
                chk("carry_after_oper", carry, pend.carry);
                acc_pend = 1'b0;
            end
            if (prev_req && !prev_hs) begin
                chk("req_held", mem_rd_req, 1);
                chk("addr_stable", mem_addr, prev_addr);
            end
            nctl = int'(clear_pc) + int'(inc_pc) + int'(load_pc);
            chk("pc_ctrl_onehot", nctl <= 1, 1);
            if (inc_pc) inc_cnt++;
            if (load_pc) begin
                jmp_cnt++;
                jmp_addr = pc_jump_addr;
            end
            hs = mem_rd_req && mem_rd_ack;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_addr", mem_addr, e.addr);
                    chk("inc_on_fetch", inc_pc, !e.oper);
                    if (e.oper) begin
                        pend     = e;
                        acc_pend = 1'b1;
                    end
                end
            end else begin
                chk("inc_idle", inc_pc, 0);
            end
            prev_req  = mem_rd_req;
            prev_hs   = hs;
            prev_addr = mem_addr;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    endtask

    // Random program: code in 0..31, forward-only jumps, data in 32..63, so it always halts.
    task automatic gen_random();
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 31; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)      mem[i] = {2'b00, 6'($urandom_range(32, 63))};
            else if (r < 8) mem[i] = {2'b01, 6'($urandom_range(32, 63))};
            else if (r < 9) mem[i] = {2'b10, 6'($urandom_range(i + 1, 31))};
            else            mem[i] = 8'hC0;
        end
        mem[31] = 8'hC0;
    endtask

    task automatic run_prog(input string tag, input int wm, input bit spur, input int exp_lat);
        int n;
        wmode   = wm;
        spur_en = spur;
        inc_cnt = 0;
        jmp_cnt = 0;
        build_expect();
        mon_en = 1'b1;
        @(negedge clock);
        start = 1'b1;
        #2;
        chk({tag, "_clear_pulse"}, clear_pc, 1);
        @(negedge clock);
        start = 1'b0;
        #2;
        chk({tag, "_clear_once"}, clear_pc, 0);
        chk({tag, "_first_req"}, mem_rd_req, 1);
        chk({tag, "_first_addr"}, mem_addr, 0);
        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk({tag, "_halted"}, halted, 1);
        if (exp_lat > 0) chk({tag, "_latency"}, n, exp_lat);
        @(negedge clock);
        #2;
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
        chk({tag, "_acc"}, acc, exp_acc);
        chk({tag, "_carry"}, carry, exp_carry);
        chk({tag, "_busy_low"}, busy, 0);
        mon_en = 1'b0;
        exp_q.delete();
    endtask

    // Global watchdog so a stuck design still reports.
    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_mem();

        // Reset state.
        repeat (3) @(negedge clock);
        #2;
        chk("rst_req", mem_rd_req, 0);
        chk("rst_clear", clear_pc, 0);
        chk("rst_inc", inc_pc, 0);
        chk("rst_load", load_pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_jump_addr", pc_jump_addr, 0);
        chk("rst_acc", acc, 0);
        chk("rst_carry", carry, 0);
        @(negedge clock);
        reset = 1'b1;

        // LDA 5, ADD 6, HLT: 0x20 + 0x13.
        mem[0] = 8'h05; mem[1] = 8'h46; mem[2] = 8'hC0; mem[5] = 8'h20; mem[6] = 8'h13;
        run_prog("ldadd", 0, 1'b0, 8);
        chk("ldadd_acc_const", acc, 8'h33);
        chk("ldadd_carry_const", carry, 0);
        chk("ldadd_inc_count", inc_cnt, 3);

        // Carry wrap: 0xF0 + 0x25.
        mem[5] = 8'hF0; mem[6] = 8'h25;
        run_prog("carry", 0, 1'b0, 8);
        chk("carry_acc_const", acc, 8'h15);
        chk("carry_flag_const", carry, 1);

        // Three wait cycles on every read: 5 reads add 15 cycles.
        mem[5] = 8'h20; mem[6] = 8'h13;
        run_prog("wait3", 3, 1'b0, 23);
        chk("wait3_inc_count", inc_cnt, 3);

        // Spurious acks outside request cycles change nothing.
        run_prog("spur", 0, 1'b1, 8);
        chk("spur_acc_const", acc, 8'h33);

        // JMP 3 then HLT.
        clear_mem();
        mem[0] = 8'h83; mem[3] = 8'hC0;
        run_prog("jmp", 0, 1'b0, 4);
        chk("jmp_load_count", jmp_cnt, 1);
        chk("jmp_target", jmp_addr, 3);

        // Random programs, random waits and spurious acks.
        for (int t = 0; t < 10; t++) begin
            gen_random();
            run_prog("rand", 4, 1'($urandom_range(0, 1)), 0);
        end

        // Reset during the second operand read.
        clear_mem();
        mem[0] = 8'h05; mem[1] = 8'h06; mem[5] = 8'h20; mem[6] = 8'h77;
        wmode   = 3;
        spur_en = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #2;
        n = 0;
        while (!(mem_rd_req && busy && mem_addr == 6'd6) && n < 200) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk("mid_reach_oper", mem_rd_req && mem_addr == 6'd6, 1);
        chk("mid_acc_before", acc, 8'h20);
        reset = 1'b0;
        #1;
        chk("mid_req_drop", mem_rd_req, 0);
        chk("mid_acc_zero", acc, 0);
        chk("mid_busy_low", busy, 0);
        chk("mid_addr_zero", mem_addr, 0);
        force_ack = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #2;
        chk("late_ack_busy", busy, 0);
        chk("late_ack_req", mem_rd_req, 0);
        chk("late_ack_acc", acc, 0);
        chk("late_ack_halted", halted, 0);
        force_ack = 1'b0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
